// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: PC sequencer for a 1-cycle synchronous instruction memory with replay, redirect and halt; perf counters under IFETCH_PERF_EN
module ifetch_ctrl #(
    parameter int          MEM_WORDS = 1024,
    parameter int          ADDR_W    = $clog2(MEM_WORDS),
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [31:0]       out_pc,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    input  logic              halt_req,
    output logic              halted,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stalls
);
    localparam logic [1:0] RUN    = 2'd0;
    localparam logic [1:0] DRAIN  = 2'd1;
    localparam logic [1:0] HALTED = 2'd2;

    logic [1:0]  state;
    logic [31:0] pc_f;
    logic [31:0] resp_pc;
    logic        resp_valid;
    logic        accept;
    logic        stall;
    logic [31:0] redir_tgt;

    // handshake view of the in-flight response; a stalled response re-reads its own word
    always_comb begin
        out_valid = resp_valid & ~redirect_valid;
        out_pc    = resp_pc;
        out_instr = imem_instr;
        accept    = out_valid & out_ready;
        stall     = resp_valid & ~out_ready & ~redirect_valid;
        imem_addr = stall ? resp_pc[ADDR_W+1:2] : pc_f[ADDR_W+1:2];
        halted    = state == HALTED;
        redir_tgt = redirect_pc & 32'hFFFF_FFFC;
    end

    // launch/hold/halt sequencing; a redirect overrides the PC and squashes the response
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_f       <= RESET_PC;
            resp_valid <= 1'b0;
            resp_pc    <= 32'd0;
            state      <= RUN;
        end else begin
            case (state)
                RUN: begin
                    if (halt_req && resp_valid && !accept && !redirect_valid) begin
                        state <= DRAIN;
                    end else if (halt_req) begin
                        state      <= HALTED;
                        resp_valid <= 1'b0;
                    end else begin
                        resp_valid <= 1'b1;
                        if (!stall) begin
                            resp_pc <= pc_f;
                            pc_f    <= pc_f + 32'd4;
                        end
                    end
                end
                DRAIN: begin
                    if (accept || redirect_valid) begin
                        resp_valid <= 1'b0;
                        state      <= HALTED;
                    end
                end
                HALTED: begin
                    if (!halt_req) begin
                        state      <= RUN;
                        resp_valid <= 1'b1;
                        resp_pc    <= pc_f;
                        pc_f       <= pc_f + 32'd4;
                    end
                end
                default: state <= RUN;
            endcase
            if (redirect_valid) begin
                resp_valid <= 1'b0;
                pc_f       <= redir_tgt;
            end
        end
    end

`ifdef IFETCH_PERF_EN
    // count delivered instructions and backpressured cycles
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_fetched <= 32'd0;
            perf_stalls  <= 32'd0;
        end else begin
            if (accept) perf_fetched <= perf_fetched + 32'd1;
            if (resp_valid && !out_ready && state != HALTED) perf_stalls <= perf_stalls + 32'd1;
        end
    end
`else
    assign perf_fetched = 32'd0;
    assign perf_stalls  = 32'd0;
`endif

    // a response held under backpressure must not change
    assert property (@(posedge clk) disable iff (!reset)
        out_valid && !out_ready |=> !out_valid || ($stable(out_pc) && $stable(out_instr)));

endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb_ifetch_ctrl: directed scoreboard bench for ifetch_ctrl against a 1024-word synchronous memory
module tb_ifetch_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  imem_addr;
    logic [31:0] imem_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        halted;
    logic [31:0] perf_fetched;
    logic [31:0] perf_stalls;
    logic [31:0] mem [1024];
    logic [31:0] q [$];
    int          compared = 0;
    int          mismatched = 0;

    always #5 clk = ~clk;

    ifetch_ctrl dut (
        .clk(clk),
        .reset(reset),
        .imem_addr(imem_addr),
        .imem_instr(imem_instr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr(out_instr),
        .out_pc(out_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .halt_req(halt_req),
        .halted(halted),
        .perf_fetched(perf_fetched),
        .perf_stalls(perf_stalls)
    );

    always_ff @(posedge clk) imem_instr <= mem[imem_addr];

    function automatic logic [31:0] model(input logic [31:0] pc);
        return 32'h100 + ((pc >> 2) & 32'h3FF);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push2(input logic [31:0] a, input logic [31:0] b);
        q.push_back(a);
        q.push_back(b);
    endtask

    task automatic cyc(input int ev, input int hp = -1);
        logic [31:0] e;
        @(negedge clk);
        if (ev >= 0) chk("out_valid", 32'(out_valid), 32'(ev));
        if (hp >= 0) begin
            chk("hold_pc", out_pc, 32'(hp));
            chk("hold_instr", out_instr, model(32'(hp)));
        end
        if (out_valid && out_ready) begin
            compared++;
            assert (q.size() > 0) else begin
                mismatched++;
                $error("FAIL sb_underflow observed=accept of pc %h expected=no accept", out_pc);
            end
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("out_pc", out_pc, e);
                chk("out_instr", out_instr, model(e));
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $fatal(1, "FAIL watchdog observed=timeout expected=finish");
    end

    initial begin
        logic [31:0] exp_fetched, exp_stalls;
`ifdef IFETCH_PERF_EN
        exp_fetched = 32'd10;
        exp_stalls  = 32'd3;
`else
        exp_fetched = 32'd0;
        exp_stalls  = 32'd0;
`endif
        for (int i = 0; i < 1024; i++) mem[i] = 32'h100 + 32'(i);
        reset = 1'b0;
        out_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;
        halt_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        cyc(0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_fetched", perf_fetched, 32'd0);
        chk("rst_stalls", perf_stalls, 32'd0);
        reset = 1'b1;
        out_ready = 1'b1;
        cyc(0);
        push2(32'h0, 32'h4);
        repeat (2) cyc(1);
        out_ready = 1'b0;
        repeat (3) cyc(1, 32'h8);
        out_ready = 1'b1;
        push2(32'h8, 32'hC);
        q.push_back(32'h10);
        repeat (3) cyc(1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h43;
        cyc(0);
        redirect_valid = 1'b0;
        cyc(0);
        push2(32'h40, 32'h44);
        repeat (2) cyc(1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h14;
        cyc(0);
        redirect_valid = 1'b0;
        cyc(0);
        push2(32'h14, 32'h18);
        q.push_back(32'h1C);
        repeat (3) cyc(1);
        chk("perf_fetched", perf_fetched, exp_fetched);
        chk("perf_stalls", perf_stalls, exp_stalls);
        halt_req = 1'b1;
        out_ready = 1'b0;
        cyc(1, 32'h20);
        chk("drain_halted", 32'(halted), 32'd0);
        out_ready = 1'b1;
        q.push_back(32'h20);
        cyc(1);
        chk("halted", 32'(halted), 32'd1);
        repeat (2) cyc(0);
        chk("halted_hold", 32'(halted), 32'd1);
        chk("halt_addr", 32'(imem_addr), 32'd9);
        halt_req = 1'b0;
        cyc(0);
        chk("resumed", 32'(halted), 32'd0);
        push2(32'h24, 32'h28);
        repeat (2) cyc(1);
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFC;
        cyc(0);
        redirect_valid = 1'b0;
        cyc(0);
        push2(32'hFFC, 32'h1000);
        repeat (2) cyc(1);
        reset = 1'b0;
        out_ready = 1'b0;
        cyc(-1);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_halted", 32'(halted), 32'd0);
        chk("mid_rst_fetched", perf_fetched, 32'd0);
        chk("mid_rst_stalls", perf_stalls, 32'd0);
        reset = 1'b1;
        out_ready = 1'b1;
        cyc(0);
        push2(32'h0, 32'h4);
        repeat (2) cyc(1);
        chk("sb_empty", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
